// File: rtl/kgp_control_unit_pkg.sv
// Shared types and constants for the KGP-miniRISC multi-cycle control unit:
// state codes, instruction classes, ALU/branch function codes and the packed control word.
package kgp_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } instr_class_e;

  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LW     = 2;
  localparam int OP_SW     = 3;
  localparam int OP_BRANCH = 4;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_COMP = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam int         ALU_LAST = 10;

  localparam logic [3:0] BR_BR   = 4'd0;
  localparam logic [3:0] BR_BLTZ = 4'd1;
  localparam logic [3:0] BR_BZ   = 4'd2;
  localparam logic [3:0] BR_BNZ  = 4'd3;
  localparam logic [3:0] BR_BL   = 4'd4;
  localparam logic [3:0] BR_BCY  = 4'd5;
  localparam logic [3:0] BR_BNCY = 4'd6;

  localparam logic [1:0] REGW_NONE = 2'b00;
  localparam logic [1:0] REGW_ALU  = 2'b01;
  localparam logic [1:0] REGW_MEM  = 2'b10;

  localparam logic [1:0] RWMUX_PC  = 2'b00;
  localparam logic [1:0] RWMUX_MEM = 2'b01;
  localparam logic [1:0] RWMUX_ALU = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] reg_write;
    logic       imm_mux_ctrl;
    logic       alu_mux_ctrl;
    logic [3:0] alu_op;
    logic       dmem_enable;
    logic       dmem_write_enable;
    logic [1:0] reg_write_mux_ctrl;
    logic [4:0] br_op;
    logic       instr_done;
    logic       illegal_instr;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/kgp_control_unit_decode.sv
// Combinational instruction decoder: opcode/func -> instruction class, ALU function,
// branch op and illegal flag.
module kgp_control_unit_decode
  import kgp_control_unit_pkg::*;
#(
  parameter int             OPW         = 6,
  parameter int             FW          = 6,
  parameter logic [OPW-1:0] HALT_OPCODE = OPW'(HALT_OPCODE_DEFAULT)
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  func,
  output instr_class_e   instr_class,
  output logic [3:0]     alu_op,
  output logic [4:0]     br_op,
  output logic           illegal
);

  // Halt is tested first so a HALT_OPCODE that collides with a class opcode still halts.
  always_comb begin
    instr_class = CLS_ILL;
    alu_op      = ALU_ADD;
    br_op       = 5'b0;
    if (opcode == HALT_OPCODE) begin
      instr_class = CLS_HALT;
    end else if (opcode == OPW'(OP_RTYPE)) begin
      if (func <= FW'(ALU_LAST)) begin
        instr_class = CLS_R;
        alu_op      = func[3:0];
      end
    end else if (opcode == OPW'(OP_ITYPE)) begin
      instr_class = CLS_I;
      alu_op      = func[3:0];
    end else if (opcode == OPW'(OP_LW)) begin
      instr_class = CLS_LW;
    end else if (opcode == OPW'(OP_SW)) begin
      instr_class = CLS_SW;
    end else if (opcode == OPW'(OP_BRANCH)) begin
      if (func <= FW'(BR_BNCY)) begin
        instr_class = CLS_BR;
        br_op       = {1'b1, func[3:0]};
      end
    end
    illegal = (instr_class == CLS_ILL);
  end

endmodule

// File: rtl/kgp_control_unit.sv
// Multi-cycle control FSM for the KGP-miniRISC core. Every output is a flop loaded
// from the control word of the state being entered, so outputs track the current state.
module kgp_control_unit
  import kgp_control_unit_pkg::*;
#(
  parameter int             OPW         = 6,
  parameter int             FW          = 6,
  parameter logic [OPW-1:0] HALT_OPCODE = OPW'(HALT_OPCODE_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  func,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     reg_write,
  output logic           imm_mux_ctrl,
  output logic           alu_mux_ctrl,
  output logic [3:0]     alu_op,
  output logic           dmem_enable,
  output logic           dmem_write_enable,
  output logic [1:0]     reg_write_mux_ctrl,
  output logic [4:0]     br_op,
  output logic           instr_done,
  output logic           illegal_instr,
  output logic           halted
);

  state_e         state_q, state_d;
  logic           first_q, first_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [FW-1:0]  func_q, func_d;
  ctrl_t          ctrl_q, ctrl_d;

  logic [OPW-1:0] dec_opcode;
  logic [FW-1:0]  dec_func;
  instr_class_e   dec_class;
  logic [3:0]     dec_alu_op;
  logic [4:0]     dec_br_op;
  logic           dec_illegal;
  logic           operand_class;

  // While leaving DECODE the live inputs are decoded so EXEC outputs can be registered
  // on the same edge that captures opcode/func; afterwards only the latched copy is used.
  assign dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;
  assign dec_func   = (state_q == ST_DECODE) ? func   : func_q;

  kgp_control_unit_decode #(
    .OPW         (OPW),
    .FW          (FW),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .opcode      (dec_opcode),
    .func        (dec_func),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .br_op       (dec_br_op),
    .illegal     (dec_illegal)
  );

  assign operand_class = (dec_class == CLS_R)  || (dec_class == CLS_I) ||
                         (dec_class == CLS_LW) || (dec_class == CLS_SW);

  always_comb begin
    opcode_d = opcode_q;
    func_d   = func_q;
    if (state_q == ST_DECODE) begin
      opcode_d = opcode;
      func_d   = func;
    end
  end

  // first_q holds the machine in FETCH for one edge after reset so the fetch strobes are seen.
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    if (first_q) begin
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          unique case (dec_class)
            CLS_R, CLS_I:   state_d = ST_WB;
            CLS_LW, CLS_SW: state_d = ST_MEM;
            CLS_HALT:       state_d = ST_HALT;
            default:        state_d = ST_FETCH;
          endcase
        end
        ST_MEM:    state_d = (dec_class == CLS_LW) ? ST_WB : ST_FETCH;
        ST_WB:     state_d = ST_FETCH;
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl_d = '0;
    if ((state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) && operand_class) begin
      ctrl_d.alu_op       = dec_alu_op;
      ctrl_d.alu_mux_ctrl = (dec_class != CLS_R);
      ctrl_d.imm_mux_ctrl = (dec_class == CLS_LW) || (dec_class == CLS_SW);
    end
    unique case (state_d)
      ST_FETCH: begin
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      ST_EXEC: begin
        if (dec_illegal) begin
          ctrl_d.illegal_instr = 1'b1;
          ctrl_d.instr_done    = 1'b1;
        end else if (dec_class == CLS_BR) begin
          ctrl_d.br_op      = dec_br_op;
          ctrl_d.pc_write   = 1'b1;
          ctrl_d.instr_done = 1'b1;
          if (dec_br_op[3:0] == BR_BL) begin
            ctrl_d.reg_write          = REGW_ALU;
            ctrl_d.reg_write_mux_ctrl = RWMUX_PC;
          end
        end
      end
      ST_MEM: begin
        ctrl_d.dmem_enable = 1'b1;
        if (dec_class == CLS_SW) begin
          ctrl_d.dmem_write_enable = 1'b1;
          ctrl_d.instr_done        = 1'b1;
        end
      end
      ST_WB: begin
        ctrl_d.instr_done = 1'b1;
        if (dec_class == CLS_LW) begin
          ctrl_d.reg_write          = REGW_MEM;
          ctrl_d.reg_write_mux_ctrl = RWMUX_MEM;
          ctrl_d.dmem_enable        = 1'b1;
        end else begin
          ctrl_d.reg_write          = REGW_ALU;
          ctrl_d.reg_write_mux_ctrl = RWMUX_ALU;
        end
      end
      ST_HALT: ctrl_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      first_q  <= 1'b1;
      opcode_q <= '0;
      func_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      opcode_q <= opcode_d;
      func_q   <= func_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ir_write           = ctrl_q.ir_write;
  assign pc_write           = ctrl_q.pc_write;
  assign reg_write          = ctrl_q.reg_write;
  assign imm_mux_ctrl       = ctrl_q.imm_mux_ctrl;
  assign alu_mux_ctrl       = ctrl_q.alu_mux_ctrl;
  assign alu_op             = ctrl_q.alu_op;
  assign dmem_enable        = ctrl_q.dmem_enable;
  assign dmem_write_enable  = ctrl_q.dmem_write_enable;
  assign reg_write_mux_ctrl = ctrl_q.reg_write_mux_ctrl;
  assign br_op              = ctrl_q.br_op;
  assign instr_done         = ctrl_q.instr_done;
  assign illegal_instr      = ctrl_q.illegal_instr;
  assign halted             = ctrl_q.halted;

endmodule

// File: tb/tb_kgp_control_unit.sv
// Directed self-checking bench for kgp_control_unit: walks each instruction class cycle by
// cycle and compares the full control word against hand-written expectations.
module tb_kgp_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       ir_write, pc_write, imm_mux_ctrl, alu_mux_ctrl;
  logic       dmem_enable, dmem_write_enable, instr_done, illegal_instr, halted;
  logic [1:0] reg_write, reg_write_mux_ctrl;
  logic [3:0] alu_op;
  logic [4:0] br_op;

  int total = 0;
  int bad   = 0;

  kgp_control_unit dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .func               (func),
    .ir_write           (ir_write),
    .pc_write           (pc_write),
    .reg_write          (reg_write),
    .imm_mux_ctrl       (imm_mux_ctrl),
    .alu_mux_ctrl       (alu_mux_ctrl),
    .alu_op             (alu_op),
    .dmem_enable        (dmem_enable),
    .dmem_write_enable  (dmem_write_enable),
    .reg_write_mux_ctrl (reg_write_mux_ctrl),
    .br_op              (br_op),
    .instr_done         (instr_done),
    .illegal_instr      (illegal_instr),
    .halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: ir, pc, reg_write, imm_mux, alu_mux, alu_op, dmem_en, dmem_we, rwmux, br_op, done, illegal, halted
  function automatic logic [21:0] packCtl(
    input logic ir, input logic pc, input logic [1:0] rw, input logic im, input logic am,
    input logic [3:0] aop, input logic de, input logic dw, input logic [1:0] rwm,
    input logic [4:0] br, input logic dn, input logic il, input logic hl);
    return {ir, pc, rw, im, am, aop, de, dw, rwm, br, dn, il, hl};
  endfunction

  function automatic logic [21:0] observed();
    return packCtl(ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
                   dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
                   instr_done, illegal_instr, halted);
  endfunction

  localparam logic [21:0] IDLE  = 22'h0;
  localparam logic [21:0] FETCH = {1'b1, 1'b1, 20'h0};

  task automatic checkOutput(input string tag, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  task automatic expectCycle(input string tag, input logic [21:0] exp);
    @(negedge clk);
    checkOutput(tag, observed(), exp);
  endtask

  // Release reset at a negedge; the following negedge shows the FETCH strobes.
  task automatic releaseReset();
    rst = 1'b1;
    expectCycle("fetch_after_reset", FETCH);
  endtask

  logic [21:0] ld_st_exec;

  initial begin
    rst = 1'b0;
    applyStimulus(6'd0, 6'd0);
    ld_st_exec = packCtl(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

    expectCycle("reset_0", IDLE);
    expectCycle("reset_1", IDLE);
    releaseReset();

    // R-type xor; the opcode is corrupted during EXEC to prove the latched copy is used
    applyStimulus(6'd0, 6'd3);
    expectCycle("xor_decode", IDLE);
    expectCycle("xor_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0));
    applyStimulus(6'h2A, 6'h3F);
    expectCycle("xor_wb", packCtl(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 2'b10, 5'd0, 1'b1, 1'b0, 1'b0));
    expectCycle("xor_next_fetch", FETCH);

    // I-type and
    applyStimulus(6'd1, 6'd2);
    expectCycle("andi_decode", IDLE);
    expectCycle("andi_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0));
    expectCycle("andi_wb", packCtl(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'b10, 5'd0, 1'b1, 1'b0, 1'b0));
    expectCycle("andi_next_fetch", FETCH);

    // sw
    applyStimulus(6'd3, 6'd0);
    expectCycle("sw_decode", IDLE);
    expectCycle("sw_exec", ld_st_exec);
    expectCycle("sw_mem", packCtl(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0));
    expectCycle("sw_next_fetch", FETCH);

    // lw
    applyStimulus(6'd2, 6'd0);
    expectCycle("lw_decode", IDLE);
    expectCycle("lw_exec", ld_st_exec);
    expectCycle("lw_mem", packCtl(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0));
    expectCycle("lw_wb", packCtl(1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0));
    expectCycle("lw_next_fetch", FETCH);

    // bl
    applyStimulus(6'd4, 6'd4);
    expectCycle("bl_decode", IDLE);
    expectCycle("bl_exec", packCtl(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 5'b10100, 1'b1, 1'b0, 1'b0));
    expectCycle("bl_next_fetch", FETCH);

    // bz: plain branch, no link write
    applyStimulus(6'd4, 6'd2);
    expectCycle("bz_decode", IDLE);
    expectCycle("bz_exec", packCtl(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 5'b10010, 1'b1, 1'b0, 1'b0));
    expectCycle("bz_next_fetch", FETCH);

    // R-type func 10 is the last legal ALU op
    applyStimulus(6'd0, 6'd10);
    expectCycle("r10_decode", IDLE);
    expectCycle("r10_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0));
    expectCycle("r10_wb", packCtl(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 2'b10, 5'd0, 1'b1, 1'b0, 1'b0));
    expectCycle("r10_next_fetch", FETCH);

    // Illegal cases: R func 11, branch func 7, undefined opcode 0x2A
    applyStimulus(6'd0, 6'd11);
    expectCycle("r11_decode", IDLE);
    expectCycle("r11_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0));
    expectCycle("r11_next_fetch", FETCH);

    applyStimulus(6'd4, 6'd7);
    expectCycle("br7_decode", IDLE);
    expectCycle("br7_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0));
    expectCycle("br7_next_fetch", FETCH);

    applyStimulus(6'h2A, 6'd0);
    expectCycle("ill_decode", IDLE);
    expectCycle("ill_exec", packCtl(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0));
    expectCycle("ill_next_fetch", FETCH);

    // Halt: stays halted for 20 cycles whatever the opcode does
    applyStimulus(6'h3F, 6'd0);
    expectCycle("halt_decode", IDLE);
    expectCycle("halt_exec", IDLE);
    for (int i = 0; i < 20; i++) begin
      expectCycle($sformatf("halted_%0d", i), {21'h0, 1'b1});
      applyStimulus(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end

    // Only reset leaves HALT
    rst = 1'b0;
    #1;
    checkOutput("halt_reset", observed(), IDLE);
    applyStimulus(6'd3, 6'd0);
    @(negedge clk);
    releaseReset();

    // Reset during sw MEM must kill the write strobe before the next edge
    expectCycle("sw2_decode", IDLE);
    expectCycle("sw2_exec", ld_st_exec);
    expectCycle("sw2_mem", packCtl(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0));
    #1;
    rst = 1'b0;
    #1;
    checkOutput("sw2_async_reset", observed(), IDLE);
    @(negedge clk);
    checkOutput("sw2_held_reset", observed(), IDLE);
    applyStimulus(6'd0, 6'd3);
    releaseReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
